// File: rtl/sram_sp_be_arb.sv
// sram_sp_be_arb: shares one bit-enable single-port SRAM (with written-flags) among NUM_REQ requesters.
// Latency: accept -> SRAM command 1 cycle; read accept -> rsp_val_o after 1+RD_LAT cycles, in order.
// Backpressure: req_rdy_o low during start_i, and for a read candidate while the tag FIFO is full.
// Optional: define SRAM_ARB_FIX_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.

// gen_fifo: small generic synchronous FIFO, head visible combinationally.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module gen_fifo #(
    parameter int WD    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_vld,
    input  logic [WD-1:0] push_dat,
    input  logic          pop_rdy,
    output logic [WD-1:0] head_dat,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WD-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == FULL_CNT);
    assign do_pop   = pop_rdy && !empty;
    // When full, a simultaneous pop frees the head slot, which is exactly the slot the tail points at.
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage: write the tail entry on push
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy count, wrapping at DEPTH (not necessarily a power of two)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// sram_sp_be_arb: arbiter + command register + in-order read-response router for one SRAM.
// Latency: 1-cycle registered command; response 1+RD_LAT cycles after a read accept.
// Backpressure: per-requester req_rdy_o; start_i blocks all, full tag FIFO blocks reads only.
module sram_sp_be_arb #(
    parameter int NUM_REQ  = 2,
    parameter int SIZE     = 16,
    parameter int SIZE_WD  = $clog2(SIZE),
    parameter int SIZE_COL = 8,
    parameter int DATA_WD  = 32,
    parameter int MSK_WD   = DATA_WD / SIZE_COL,
    parameter int RD_LAT   = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    input  logic [NUM_REQ-1:0]         req_val_i,
    output logic [NUM_REQ-1:0]         req_rdy_o,
    input  logic [NUM_REQ-1:0]         req_rd_i,
    input  logic [NUM_REQ*SIZE_WD-1:0] req_adr_i,
    input  logic [NUM_REQ*MSK_WD-1:0]  req_msk_i,
    input  logic [NUM_REQ*DATA_WD-1:0] req_dat_i,
    output logic [NUM_REQ-1:0]         rsp_val_o,
    output logic [DATA_WD-1:0]         rsp_dat_o,
    output logic                       sram_start_o,
    output logic [SIZE_WD-1:0]         sram_adr_o,
    output logic [MSK_WD-1:0]          sram_wr_val_o,
    output logic [DATA_WD-1:0]         sram_wr_dat_o,
    output logic                       sram_rd_val_o,
    input  logic                       sram_rd_val_i,
    input  logic [DATA_WD-1:0]         sram_rd_dat_i
);
    localparam int PTR_WD     = $clog2(NUM_REQ);
    localparam int IDX_WD     = PTR_WD + 1;
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam logic [IDX_WD-1:0] NUM_REQ_IDX  = IDX_WD'(NUM_REQ);
    localparam logic [PTR_WD-1:0] LAST_REQ_PTR = PTR_WD'(NUM_REQ - 1);

    typedef struct packed {
        logic               rd;
        logic [SIZE_WD-1:0] adr;
        logic [MSK_WD-1:0]  msk;
        logic [DATA_WD-1:0] dat;
    } req_t;

    typedef struct packed {
        logic               start;
        logic               rd_val;
        logic [MSK_WD-1:0]  wr_val;
        logic [SIZE_WD-1:0] adr;
        logic [DATA_WD-1:0] wr_dat;
    } cmd_t;

    req_t               req [NUM_REQ];
    req_t               cand;
    logic [PTR_WD-1:0]  ptr_q;
    logic [PTR_WD-1:0]  ptr_d;
    logic [IDX_WD-1:0]  idx_sum;
    logic [PTR_WD-1:0]  cand_idx;
    logic               cand_found;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    cmd_t               cmd_q;
    cmd_t               cmd_d;
    logic               tag_full;
    logic               tag_empty;
    logic [NUM_REQ-1:0] tag_head;

    // Unpack the flat request buses into per-requester records
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req[k].rd  = req_rd_i[k];
            req[k].adr = req_adr_i[k*SIZE_WD +: SIZE_WD];
            req[k].msk = req_msk_i[k*MSK_WD +: MSK_WD];
            req[k].dat = req_dat_i[k*DATA_WD +: DATA_WD];
        end
    end

    // Candidate search: first valid requester at or above the pointer, wrapping around
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        idx_sum    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_sum = {1'b0, ptr_q} + IDX_WD'(i);
            if (idx_sum >= NUM_REQ_IDX) begin
                idx_sum = idx_sum - NUM_REQ_IDX;
            end
            if (!cand_found && req_val_i[idx_sum[PTR_WD-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = idx_sum[PTR_WD-1:0];
            end
        end
    end

    assign cand = req[cand_idx];

    // Grant the candidate unless a frame start is pending or a read would overflow the tag FIFO.
    // A blocked read candidate is not skipped: the pointer-order stays fair.
    always_comb begin
        grant = '0;
        if (cand_found && !start_i && !(tag_full && cand.rd)) begin
            grant[cand_idx] = 1'b1;
        end
    end

    assign req_rdy_o = grant;
    assign accept    = |grant;

    // Next arbitration pointer
    always_comb begin
        ptr_d = ptr_q;
`ifdef SRAM_ARB_FIX_PRIO_EN
        // Fixed priority: always search from requester 0.
        ptr_d = '0;
`else
        if (accept) begin
            ptr_d = (cand_idx == LAST_REQ_PTR) ? '0 : cand_idx + 1'b1;
        end
`endif
    end

    // Pointer register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Next SRAM command: strobes default low, address/write data hold when idle.
    // The start pulse goes out alone since accept is impossible while start_i is high.
    always_comb begin
        cmd_d        = cmd_q;
        cmd_d.start  = start_i;
        cmd_d.rd_val = 1'b0;
        cmd_d.wr_val = '0;
        if (accept) begin
            cmd_d.adr = cand.adr;
            if (cand.rd) begin
                cmd_d.rd_val = 1'b1;
            end else begin
                cmd_d.wr_val = cand.msk;
                cmd_d.wr_dat = cand.dat;
            end
        end
    end

    // Command register driving the SRAM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign sram_start_o  = cmd_q.start;
    assign sram_adr_o    = cmd_q.adr;
    assign sram_wr_val_o = cmd_q.wr_val;
    assign sram_wr_dat_o = cmd_q.wr_dat;
    assign sram_rd_val_o = cmd_q.rd_val;

    // Tag FIFO remembers which requester issued each outstanding read, in issue order
    gen_fifo #(
        .WD    (NUM_REQ),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push_vld (accept && cand.rd),
        .push_dat (grant),
        .pop_rdy  (sram_rd_val_i),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // Stray read data with nothing outstanding is not routed anywhere
    assign rsp_val_o = tag_empty ? '0 : (tag_head & {NUM_REQ{sram_rd_val_i}});
    assign rsp_dat_o = sram_rd_dat_i;
endmodule
